// File: rtl/vadd_fp16_pipe.sv
// Three-stage binary16 adder lane: align (S1), add/subtract (S2), normalize/round/pack (S3).
// Truncating by default; define VADDP_RNE_EN for round-to-nearest-even.
module vadd_fp16_pipe (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [15:0] Sum,
   output logic        Ov
);

   // Leading-zero count of the 14-bit working mantissa; 14 means all-zero.
   function automatic logic [3:0] lzc14(input logic [13:0] v);
      logic [3:0] n;
      n = 4'd14;
      for (int i = 0; i < 14; i++)
         if (v[i]) n = 4'(13 - i);
      return n;
   endfunction

   // ---------------- S1: unpack, order, align ----------------
   logic [4:0]  ea, eb, ex, ey, d;
   logic        a_spec, b_spec, a_ge;
   logic [14:0] mag_a, mag_b, mag_x, mag_y;
   logic [13:0] mx, my, y_sh, y_mask;
   logic        sign_x;

   assign ea     = A[14:10];
   assign eb     = B[14:10];
   assign a_spec = (ea == 5'h1F);
   assign b_spec = (eb == 5'h1F);
   assign mag_a  = (ea == 5'd0) ? 15'd0 : A[14:0];
   assign mag_b  = (eb == 5'd0) ? 15'd0 : B[14:0];
   assign a_ge   = (mag_a >= mag_b);
   assign mag_x  = a_ge ? mag_a : mag_b;
   assign mag_y  = a_ge ? mag_b : mag_a;
   assign sign_x = a_ge ? A[15] : B[15];
   assign ex     = mag_x[14:10];
   assign ey     = mag_y[14:10];
   assign d      = ex - ey;
   assign mx     = (ex == 5'd0) ? 14'd0 : {1'b1, mag_x[9:0], 3'b000};
   assign my     = (ey == 5'd0) ? 14'd0 : {1'b1, mag_y[9:0], 3'b000};
   assign y_mask = (14'h1 << d) - 14'h1;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      y_sh = {13'd0, |my};
      if (d < 5'd14)
         y_sh = (my >> d) | {13'd0, |(my & y_mask)};
   end

   logic        s1_spec, s1_spec_sign, s1_sign, s1_sub;
   logic [4:0]  s1_exp;
   logic [13:0] s1_mx, s1_my;

   // NOTE: sequential state uses non-blocking assignments only; every pipeline
   // register (there is no memory here) is cleared by the asynchronous reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         s1_spec      <= 1'b0;
         s1_spec_sign <= 1'b0;
         s1_sign      <= 1'b0;
         s1_sub       <= 1'b0;
         s1_exp       <= 5'd0;
         s1_mx        <= 14'd0;
         s1_my        <= 14'd0;
      end else begin
         s1_spec      <= a_spec | b_spec;
         s1_spec_sign <= a_spec ? A[15] : B[15];
         s1_sign      <= sign_x;
         s1_sub       <= A[15] ^ B[15];
         s1_exp       <= ex;
         s1_mx        <= mx;
         s1_my        <= y_sh;
      end
   end

   // ---------------- S2: effective add / subtract ----------------
   logic        s2_spec, s2_spec_sign, s2_sign;
   logic [4:0]  s2_exp;
   logic [14:0] s2_sum;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         s2_spec      <= 1'b0;
         s2_spec_sign <= 1'b0;
         s2_sign      <= 1'b0;
         s2_exp       <= 5'd0;
         s2_sum       <= 15'd0;
      end else begin
         s2_spec      <= s1_spec;
         s2_spec_sign <= s1_spec_sign;
         s2_sign      <= s1_sign;
         s2_exp       <= s1_exp;
         // |X| >= |Y| so the difference never goes negative.
         s2_sum       <= s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my})
                                : ({1'b0, s1_mx} + {1'b0, s1_my});
      end
   end

   // ---------------- S3: normalize, round, pack ----------------
   logic [3:0]        lz;
   logic [13:0]       norm;
   logic signed [6:0] exp_n, exp_r;
   logic [9:0]        frac;
   logic [15:0]       sum_d;
   logic              ov_d;
   logic              unused_bits;

   assign lz = lzc14(s2_sum[13:0]);

   always_comb begin
      norm  = s2_sum[13:0] << lz;
      exp_n = $signed({2'b00, s2_exp}) - $signed({3'b000, lz});
      if (s2_sum[14]) begin
         norm  = {s2_sum[14:2], s2_sum[1] | s2_sum[0]};
         exp_n = $signed({2'b00, s2_exp}) + 7'sd1;
      end
   end

`ifdef VADDP_RNE_EN
   logic        rnd;
   logic [10:0] frac_c;

   assign rnd         = norm[2] & (norm[3] | norm[1] | norm[0]);
   assign frac_c      = {1'b0, norm[12:3]} + {10'd0, rnd};
   assign frac        = frac_c[9:0];
   // A carry out of the fraction leaves it zero and bumps the exponent.
   assign exp_r       = exp_n + $signed({6'd0, frac_c[10]});
   assign unused_bits = norm[13];
`else
   assign frac        = norm[12:3];
   assign exp_r       = exp_n;
   assign unused_bits = ^{norm[13], norm[2:0]};
`endif

   always_comb begin
      sum_d = {s2_sign, exp_r[4:0], frac};
      ov_d  = 1'b0;
      if (s2_spec) begin
         sum_d = {s2_spec_sign, 15'h7BFF};
         ov_d  = 1'b1;
      end else if (s2_sum == 15'd0 || exp_n <= 7'sd0) begin
         sum_d = 16'h0000;
      end else if (exp_r >= 7'sd31) begin
         sum_d = {s2_sign, 15'h7BFF};
         ov_d  = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Sum <= 16'h0000;
         Ov  <= 1'b0;
      end else begin
         Sum <= sum_d;
         Ov  <= ov_d;
      end
   end

endmodule

// File: tb/tb_vadd_fp16_pipe.sv
// Self-checking bench for vadd_fp16_pipe: directed vectors plus random pairs
// scored against an exact-integer binary16 reference model.
module tb_vadd_fp16_pipe;

   logic        Clk;
   logic        Rst_n;
   logic [15:0] A, B, Sum;
   logic        Ov;

   int n_vec = 0;
   int n_err = 0;

   logic [16:0] q_v[$];
   string       q_t[$];

   vadd_fp16_pipe dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .A    (A),
      .B    (B),
      .Sum  (Sum),
      .Ov   (Ov)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Value of a binary16 operand in units of 2^-24; denormals read as zero.
   function automatic longint fp_val(input logic [15:0] x);
      longint v;
      if (x[14:10] == 5'd0) return 0;
      v = longint'({1'b1, x[9:0]}) << (int'(x[14:10]) - 1);
      return x[15] ? -v : v;
   endfunction

   // Reference: exact sum, then one rounding step to binary16. Returns {Ov, Sum}.
   function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
      longint s, mag, m;
      int     p, e, sh;
      logic   sg;
      if (a[14:10] == 5'h1F || b[14:10] == 5'h1F)
         return {1'b1, (a[14:10] == 5'h1F) ? a[15] : b[15], 15'h7BFF};
      s = fp_val(a) + fp_val(b);
      if (s == 0) return 17'h0;
      sg  = (s < 0);
      mag = sg ? -s : s;
      p = 0;
      for (int i = 0; i < 63; i++)
         if (((mag >> i) & 64'd1) != 0) p = i;
      e = p - 9;
      if (e <= 0) return 17'h0;
      sh = p - 10;
      m  = mag >> sh;
`ifdef VADDP_RNE_EN
      if (sh > 0) begin
         longint rem, half;
         rem  = mag - (m << sh);
         half = longint'(1) << (sh - 1);
         if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
      end
      if (m == 2048) begin
         m = 1024;
         e = e + 1;
      end
`endif
      if (e >= 31) return {1'b1, sg, 15'h7BFF};
      return {1'b0, sg, 5'(e), 10'(m)};
   endfunction

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed Ov/Sum=%0b/%h expected %0b/%h",
                tag, obs[16], obs[15:0], expv[16], expv[15:0]);
      end
   endtask

   // Pipeline is freshly cleared: the next two outputs must be zero.
   task automatic preload_flush();
      q_v.delete();
      q_t.delete();
      q_v.push_back(17'h0); q_t.push_back("flush0");
      q_v.push_back(17'h0); q_t.push_back("flush1");
   endtask

   // Drive one operand pair, clock it in, and check the result from two edges earlier.
   task automatic step(input logic [15:0] a, input logic [15:0] b,
                       input logic [16:0] expv, input string tag);
      logic [16:0] e;
      string       t;
      A = a;
      B = b;
      @(posedge Clk);
      #1;
      q_v.push_back(expv);
      q_t.push_back(tag);
      e = q_v.pop_front();
      t = q_t.pop_front();
      check(t, {Ov, Sum}, e);
   endtask

   task automatic rstep(input logic [15:0] a, input logic [15:0] b, input string tag);
      step(a, b, ref_add(a, b), tag);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic [16:0] exp_round;
`ifdef VADDP_RNE_EN
      exp_round = {1'b0, 16'h3C01};
`else
      exp_round = {1'b0, 16'h3C00};
`endif
      Rst_n = 1'b0;
      A     = 16'h1234;
      B     = 16'h5678;
      #3;
      check("reset_state", {Ov, Sum}, 17'h0);
      @(posedge Clk);
      #1;
      check("reset_held", {Ov, Sum}, 17'h0);
      Rst_n = 1'b1;
      preload_flush();

      for (int i = 0; i < 6; i++) step(16'h9939, 16'h9939, {1'b0, 16'h9D39}, "hold_9939");
      step(16'h7A00, 16'h76F2, {1'b1, 16'h7BFF}, "ovf_7A00_76F2");
      for (int i = 0; i < 4; i++) step(16'h9939, 16'h9939, {1'b0, 16'h9D39}, "ov_clear");
      step(16'h3C00, 16'hBC00, {1'b0, 16'h0000}, "cancel");
      step(16'h3C00, 16'h3C00, {1'b0, 16'h4000}, "one_plus_one");
      step(16'h9939, 16'h9939, {1'b0, 16'h9D39}, "stream_mid");
      step(16'h7A00, 16'h76F2, {1'b1, 16'h7BFF}, "stream_ovf");
      step(16'h3C00, 16'h1200, exp_round, "round_3C00_1200");
      step(16'h7C00, 16'h3C00, {1'b1, 16'h7BFF}, "inf_a");
      step(16'h3C00, 16'hFE00, {1'b1, 16'hFBFF}, "nan_b_neg");
      step(16'hFC00, 16'h7C00, {1'b1, 16'hFBFF}, "both_inf_sign_a");
      step(16'h0200, 16'h8001, {1'b0, 16'h0000}, "denormals_zero");
      step(16'h0400, 16'h8401, {1'b0, 16'h0000}, "underflow_flush");
      step(16'h3C00, 16'h0200, {1'b0, 16'h3C00}, "denormal_plus_one");
      step(16'h7BFF, 16'h7BFF, {1'b1, 16'h7BFF}, "max_plus_max");
      step(16'hC000, 16'h3C00, {1'b0, 16'hBC00}, "neg_result");
      step(16'h3C00, 16'h2C00, ref_add(16'h3C00, 16'h2C00), "shift_4");

      for (int i = 0; i < 1200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rstep(ra, rb, "rand_uniform");
      end
      for (int i = 0; i < 600; i++) begin
         ra = 16'($urandom);
         rb = {~ra[15], ra[14:0] ^ 15'($urandom_range(0, 2047))};
         rstep(ra, rb, "rand_cancel");
      end

      // Asynchronous reset in the middle of a stream.
      rstep(16'h3C00, 16'h3C00, "pre_reset0");
      rstep(16'h7A00, 16'h76F2, "pre_reset1");
      #2;
      Rst_n = 1'b0;
      #1;
      check("async_reset", {Ov, Sum}, 17'h0);
      @(posedge Clk);
      #1;
      check("reset_hold_mid", {Ov, Sum}, 17'h0);
      #2;
      Rst_n = 1'b1;
      preload_flush();
      rstep(16'h9939, 16'h9939, "post_reset0");
      rstep(16'h7A00, 16'h76F2, "post_reset1");
      rstep(16'h3C00, 16'h1200, "post_reset2");
      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rstep(ra, rb, "rand_after_reset");
      end
      step(16'h0000, 16'h0000, 17'h0, "drain0");
      step(16'h0000, 16'h0000, 17'h0, "drain1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
